// File: rtl/ram_pkg.sv
// Shared definitions for the 256x64 single-port SRAM model.
//   ADDR_W / DATA_W : default address and data widths
//   op_e            : access type decoded from (cen, wen)
//   decode_op       : maps chip enable / write enable to an access type
package ram_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 64;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2
  } op_e;

  // Chip enable dominates; write enable only matters when the chip is enabled.
  function automatic op_e decode_op(input logic cen, input logic wen);
    op_e op;
    if (!cen) begin
      op = OP_IDLE;
    end else if (wen) begin
      op = OP_WRITE;
    end else begin
      op = OP_READ;
    end
    return op;
  endfunction

endpackage : ram_pkg

// File: rtl/ram_array.sv
// Storage array for the SRAM model: one synchronous write port and one
// combinational read port sharing a single address.
// Ports:
//   clk       : clock, writes and clears on the rising edge
//   rst       : synchronous active-high clear of every word
//   we        : write strobe (already qualified by chip enable)
//   addr      : shared word address
//   din       : write data
//   rd_data_c : combinational read of mem[addr]; registered by the parent
module ram_array #(
  parameter int unsigned ADDR_W = ram_pkg::ADDR_W,
  parameter int unsigned DATA_W = ram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] rd_data_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Reset wipes the whole array in one edge and overrides any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[ADDR_W'(i)] <= '0;
      end
    end else if (we) begin
      mem[addr] <= din;
    end
  end

  assign rd_data_c = mem[addr];

endmodule : ram_array

// File: rtl/ram_256x64.sv
// Single-port synchronous SRAM model, 256 words x 64 bits, registered read data.
// Priority at each rising edge: rst > cen > wen.
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset; clears s_dout and every memory word
//   cen    : chip enable, 1 = access this cycle
//   wen    : 1 = write, 0 = read (only when cen = 1)
//   s_addr : word address
//   s_din  : write data
//   s_dout : registered read data, one cycle after the read address
// Build option: RAM_DOUT_HOLD_EN -- when defined, s_dout keeps its value on
// write and idle cycles instead of returning to 0.
module ram_256x64 #(
  parameter int unsigned ADDR_W = ram_pkg::ADDR_W,
  parameter int unsigned DATA_W = ram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              wen,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_din,
  output logic [DATA_W-1:0] s_dout
);

  import ram_pkg::*;

  op_e               op_c;
  logic              we_c;
  logic [DATA_W-1:0] rd_data_c;

  assign op_c = decode_op(cen, wen);
  assign we_c = (op_c == OP_WRITE);

  ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .we        (we_c),
    .addr      (s_addr),
    .din       (s_din),
    .rd_data_c (rd_data_c)
  );

  // Output register: loads on reads, otherwise cleared or held per build option.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_dout <= '0;
    end else begin
      case (op_c)
        OP_READ: s_dout <= rd_data_c;
`ifdef RAM_DOUT_HOLD_EN
        default: s_dout <= s_dout;
`else
        default: s_dout <= '0;
`endif
      endcase
    end
  end

endmodule : ram_256x64

// File: tb/tb_ram_256x64.sv
// Scoreboard bench for ram_256x64: each issued cycle pushes its expected s_dout,
// a monitor pops and compares one edge later.
module tb_ram_256x64;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 64;

  logic              clk;
  logic              rst;
  logic              cen;
  logic              wen;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_din;
  logic [DATA_W-1:0] s_dout;

  int checks;
  int errors;

  logic [DATA_W-1:0] exp_q  [$];
  string             name_q [$];
  logic [DATA_W-1:0] last_read;

  ram_256x64 dut (
    .clk    (clk),
    .rst    (rst),
    .cen    (cen),
    .wen    (wen),
    .s_addr (s_addr),
    .s_din  (s_din),
    .s_dout (s_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected value on a write or idle cycle depends on the build option.
  function automatic logic [DATA_W-1:0] non_read_exp(input logic [DATA_W-1:0] last);
`ifdef RAM_DOUT_HOLD_EN
    return last;
`else
    return '0;
`endif
  endfunction

  // Drive one cycle at the falling edge and queue the value s_dout must show after the next rising edge.
  task automatic step(input string nm, input logic r, input logic c, input logic w,
                      input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic [DATA_W-1:0] read_exp);
    logic [DATA_W-1:0] e;
    @(negedge clk);
    rst = r; cen = c; wen = w; s_addr = a; s_din = d;
    if (r) begin
      e = '0;
      last_read = '0;
    end else if (c && !w) begin
      e = read_exp;
      last_read = read_exp;
    end else begin
      e = non_read_exp(last_read);
    end
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compare every queued expectation shortly after its edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [DATA_W-1:0] e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (s_dout !== e) begin
        errors++;
        $display("FAIL %s: s_dout got %h expected %h", nm, s_dout, e);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    last_read = '0;
    rst = 1'b1; cen = 1'b0; wen = 1'b0; s_addr = '0; s_din = '0;

    step("reset0", 1'b1, 1'b0, 1'b0, 8'd0, 64'h0, 64'h0);
    step("reset1", 1'b1, 1'b0, 1'b0, 8'd0, 64'h0, 64'h0);

    // Write sweep including both address extremes.
    step("wr0",   1'b0, 1'b1, 1'b1, 8'd0,   64'h1111111111111111, 64'h0);
    step("wr100", 1'b0, 1'b1, 1'b1, 8'd100, 64'h2222222222222222, 64'h0);
    step("wr234", 1'b0, 1'b1, 1'b1, 8'd234, 64'h1234567812345678, 64'h0);
    step("wr255", 1'b0, 1'b1, 1'b1, 8'd255, 64'hFFFFFFFFFFFFFFFF, 64'h0);

    // Back-to-back read back.
    step("rd0",   1'b0, 1'b1, 1'b0, 8'd0,   64'h0, 64'h1111111111111111);
    step("rd100", 1'b0, 1'b1, 1'b0, 8'd100, 64'h0, 64'h2222222222222222);
    step("rd234", 1'b0, 1'b1, 1'b0, 8'd234, 64'h0, 64'h1234567812345678);
    step("rd255", 1'b0, 1'b1, 1'b0, 8'd255, 64'h0, 64'hFFFFFFFFFFFFFFFF);

    // Write attempt with chip disabled must be blocked; idle after read of 255.
    step("idle_wr", 1'b0, 1'b0, 1'b1, 8'd0, 64'h8888888888888888, 64'h0);
    step("rd0_blk", 1'b0, 1'b1, 1'b0, 8'd0, 64'h0, 64'h1111111111111111);
    step("rd1_unw", 1'b0, 1'b1, 1'b0, 8'd1, 64'h0, 64'h0);

    // Reset clears memory; an access presented during reset is discarded.
    step("rst_acc", 1'b1, 1'b1, 1'b1, 8'd5, 64'hA5A5A5A5A5A5A5A5, 64'h0);
    step("rd100_clr", 1'b0, 1'b1, 1'b0, 8'd100, 64'h0, 64'h0);
    step("rd255_clr", 1'b0, 1'b1, 1'b0, 8'd255, 64'h0, 64'h0);
    step("rd5_drop",  1'b0, 1'b1, 1'b0, 8'd5,   64'h0, 64'h0);

    // Read-after-write on consecutive cycles.
    step("wr7", 1'b0, 1'b1, 1'b1, 8'd7, 64'hDEADBEEF00000001, 64'h0);
    step("rd7", 1'b0, 1'b1, 1'b0, 8'd7, 64'h0, 64'hDEADBEEF00000001);

    // Output hold behaviour on idle and write cycles after a read.
    step("wr255b", 1'b0, 1'b1, 1'b1, 8'd255, 64'hFFFFFFFFFFFFFFFF, 64'h0);
    step("wr128",  1'b0, 1'b1, 1'b1, 8'd128, 64'h0123456789ABCDEF, 64'h0);
    step("rd255b", 1'b0, 1'b1, 1'b0, 8'd255, 64'h0, 64'hFFFFFFFFFFFFFFFF);
    step("idle1",  1'b0, 1'b0, 1'b0, 8'd255, 64'h0, 64'h0);
    step("idle2",  1'b0, 1'b0, 1'b1, 8'd128, 64'h5555555555555555, 64'h0);
    step("wr_hold", 1'b0, 1'b1, 1'b1, 8'd9, 64'h0000000000000009, 64'h0);
    step("rd128",  1'b0, 1'b1, 1'b0, 8'd128, 64'h0, 64'h0123456789ABCDEF);
    step("rd9",    1'b0, 1'b1, 1'b0, 8'd9,   64'h0, 64'h0000000000000009);
    step("idle3",  1'b0, 1'b0, 1'b0, 8'd0,   64'h0, 64'h0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ram_256x64
